// File: rtl/cache_dm_param.sv
// cache_dm_param -- direct-mapped, write-through / no-write-allocate cache
// sitting between a single-outstanding CPU port and a handshaked backing memory.
//
// Parameters:
//   DW        data word width
//   AW        word address width
//   LINE_BITS log2 of the number of cache lines
//   BLK_BITS  log2 of the words per line (tag width = AW-LINE_BITS-BLK_BITS)
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req, w, address, din  CPU request (sampled only while idle), write flag,
//                         word address, write data
//   dout, done            read data and its one-cycle completion pulse
//   busy                  high whenever an access is in progress
//   mem_addr, mem_rd, mem_wr, mem_wdata, mem_rdata, mem_ack
//                         backing-memory port; strobes held until mem_ack
//   hit_cnt, miss_cnt     saturating access statistics
//
// Build option: define CACHE_STATS_EN to enable hit/miss counters; without it
// hit_cnt and miss_cnt are tied to zero.
module cache_dm_param #(
  parameter int DW        = 8,
  parameter int AW        = 11,
  parameter int LINE_BITS = 2,
  parameter int BLK_BITS  = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          w,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
);

  localparam int TAG_W = AW - LINE_BITS - BLK_BITS;
  localparam int LINES = 1 << LINE_BITS;
  localparam int WORDS = 1 << BLK_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

  state_t state, state_n;

  logic [DW-1:0]    data_mem [LINES*WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid;

  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       din_q;
  logic                w_q;
  logic [BLK_BITS-1:0] cnt;

  logic [TAG_W-1:0]     in_tag, q_tag;
  logic [LINE_BITS-1:0] in_line, q_line;
  logic [BLK_BITS-1:0]  q_blk;
  logic                 lookup_hit, q_hit, accept, last_beat;

  assign in_tag  = address[AW-1:LINE_BITS+BLK_BITS];
  assign in_line = address[LINE_BITS+BLK_BITS-1:BLK_BITS];
  assign q_tag   = addr_q[AW-1:LINE_BITS+BLK_BITS];
  assign q_line  = addr_q[LINE_BITS+BLK_BITS-1:BLK_BITS];
  assign q_blk   = addr_q[BLK_BITS-1:0];

  assign lookup_hit = valid[in_line] && (tag_mem[in_line] == in_tag);
  // Tag/valid of the latched line cannot change during a write, so the hit
  // can be re-evaluated at the ack edge instead of being latched at accept.
  assign q_hit      = valid[q_line] && (tag_mem[q_line] == q_tag);
  assign last_beat  = (cnt == '1);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (w)               state_n = WRITE;
          else if (lookup_hit) state_n = DONE;
          else                 state_n = REFILL;
        end
      end
      REFILL: begin
        mem_rd   = 1'b1;
        mem_addr = {q_tag, q_line, cnt};
        if (mem_ack && last_beat) state_n = DONE;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = din_q;
        if (mem_ack) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control/datapath registers that reset clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= '0;
      cnt    <= '0;
      addr_q <= '0;
      din_q  <= '0;
      w_q    <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q <= address;
            din_q  <= din;
            w_q    <= w;
            cnt    <= '0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            // Valid only on the final beat, so an interrupted fill stays invalid.
            if (last_beat) valid[q_line] <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
          dout <= w_q ? din_q : data_mem[{q_line, q_blk}];
        end
        default: ;
      endcase
    end
  end

  // Data and tag storage carry no reset.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      data_mem[{q_line, cnt}] <= mem_rdata;
      if (last_beat) tag_mem[q_line] <= q_tag;
    end
    if (state == WRITE && mem_ack && q_hit)
      data_mem[{q_line, q_blk}] <= din_q;
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (lookup_hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_dm_param.sv
// Self-checking bench for cache_dm_param: directed scenarios followed by
// randomized accesses, scored against a line-level cache model and a
// bench-owned backing memory.
module tb_cache_dm_param;
  localparam int DW = 8;
  localparam int AW = 11;
  localparam int LB = 2;
  localparam int BB = 3;
  localparam int WORDS = 1 << BB;
  localparam int LINES = 1 << LB;

  logic          clk = 1'b0;
  logic          reset, req, w;
  logic [AW-1:0] address;
  logic [DW-1:0] din, dout;
  logic          done, busy;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [15:0]   hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_dm_param #(.DW(DW), .AW(AW), .LINE_BITS(LB), .BLK_BITS(BB)) dut (
    .clk(clk), .reset(reset), .req(req), .w(w), .address(address), .din(din),
    .dout(dout), .done(done), .busy(busy), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory and responder.
  logic [DW-1:0] mem [1<<AW];
  bit            mem_ready = 0;
  int            max_wait = 0;
  int            wait_left = 0;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  int            both_hi = 0;

  always @(negedge clk) begin
    if (reset) begin
      mem_ack = 1'b0;
    end else if (mem_rd || mem_wr) begin
      if (wait_left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wait_left = $urandom_range(max_wait, 0);
      end else begin
        mem_ack = 1'b0;
        wait_left--;
      end
    end else begin
      // Occasional stray ack with no strobe outstanding.
      mem_ack = ($urandom_range(9, 0) == 0);
    end
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      mem_ready = 1;
    end
    if (mem_rd && mem_wr) both_hi++;
    if (!reset && mem_ack) begin
      if (mem_rd) rd_log.push_back(mem_addr);
      if (mem_wr) begin
        wr_addr_log.push_back(mem_addr);
        wr_data_log.push_back(mem_wdata);
        mem[mem_addr] = mem_wdata;
      end
    end
  end

  // Reference model: which tag (if any) each line holds.
  bit            mvalid [LINES];
  int            mtag   [LINES];
  int            mhits = 0;
  int            mmisses = 0;

  function automatic logic [31:0] exp_hits();
`ifdef CACHE_STATS_EN
    return mhits;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef CACHE_STATS_EN
    return mmisses;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) mvalid[i] = 0;
    mhits = 0;
    mmisses = 0;
  endtask

  task automatic access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int            line = (int'(a) / WORDS) % LINES;
    int            tg   = int'(a) / (WORDS * LINES);
    bit            hit  = mvalid[line] && (mtag[line] == tg);
    int            base = int'(a) - (int'(a) % WORDS);
    logic [DW-1:0] exp_rd = mem[a];
    int            rd0 = rd_log.size();
    int            wr0 = wr_addr_log.size();
    int            cyc = 0;
    bit            got = 0;
    @(negedge clk);
    req = 1'b1; w = wr; address = a; din = d;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) req = 1'b0;
      if (done) begin got = 1; break; end
    end
    check("done_seen", got, 1);
    if (hit) mhits++; else mmisses++;
    if (!wr) begin
      check("rd_data", dout, exp_rd);
      check("refill_beats", rd_log.size() - rd0, hit ? 0 : WORDS);
      for (int i = rd0; i < rd_log.size(); i++)
        check("refill_addr", rd_log[i], base + (i - rd0));
      check("rd_no_write", wr_addr_log.size() - wr0, 0);
      if (hit) check("hit_latency", cyc, 2);
      else begin
        mvalid[line] = 1;
        mtag[line] = tg;
      end
    end else begin
      check("wr_beats", wr_addr_log.size() - wr0, 1);
      if (wr_addr_log.size() > wr0) begin
        check("wr_addr", wr_addr_log[wr0], a);
        check("wr_data", wr_data_log[wr0], d);
      end
      check("wr_no_read", rd_log.size() - rd0, 0);
    end
    check("busy_at_done", busy, 0);
    check("hit_cnt", hit_cnt, exp_hits());
    check("miss_cnt", miss_cnt, exp_misses());
    @(posedge clk); #1;
    check("done_pulse", done, 0);
  endtask

  // Read miss interrupted by reset after the third refill beat.
  task automatic abort_refill(input logic [AW-1:0] a);
    int rd0 = rd_log.size();
    int cyc = 0;
    @(negedge clk);
    req = 1'b1; w = 1'b0; address = a; din = '0;
    while (cyc < 300 && (rd_log.size() - rd0) < 3) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) req = 1'b0;
    end
    check("abort_beats", rd_log.size() - rd0, 3);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rd", mem_rd, 0);
    check("abort_done", done, 0);
    check("abort_dout", dout, 0);
    check("abort_miss_cnt", miss_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req = 1'b0; w = 1'b0; address = '0; din = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd", mem_rd, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_dout", dout, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    reset = 1'b0;

    access(1'b0, 11'h0A5, 8'h00);
    access(1'b0, 11'h0A2, 8'h00);
    access(1'b1, 11'h0A2, 8'h5C);
    access(1'b0, 11'h0A2, 8'h00);
    check("wr_hit_readback", dout, 8'h5C);
    access(1'b1, 11'h3E0, 8'h77);
    access(1'b0, 11'h3E0, 8'h00);
    check("wr_miss_readback", dout, 8'h77);
    access(1'b0, 11'h0A5, 8'h00);
    access(1'b0, 11'h1A5, 8'h00);
    access(1'b0, 11'h0A5, 8'h00);

    abort_refill(11'h2B3);
    access(1'b0, 11'h2B3, 8'h00);
    access(1'b0, 11'h0A5, 8'h00);

    max_wait = 2;
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      a = AW'(($urandom_range(3, 0) * 5) * (WORDS * LINES)
              + $urandom_range(LINES - 1, 0) * WORDS
              + $urandom_range(WORDS - 1, 0));
      access($urandom_range(3, 0) == 0, a, DW'($urandom));
    end

    check("rd_wr_exclusive", both_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_dm_param.md
CACHE_DM_PARAM -- requirements
Module: cache_dm_param

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter AW, default 11, meaning word address width.
REQ-003 The block SHALL have parameter LINE_BITS, default 2, meaning log2 of the number of cache lines.
REQ-004 The block SHALL have parameter BLK_BITS, default 3, meaning log2 of the words per line; TAG_W = AW-LINE_BITS-BLK_BITS.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 req  input  1  CPU access request, sampled only in IDLE.
REQ-009 w  input  1  1 = write, 0 = read; qualified by req.
REQ-010 address  input  AW  CPU word address: tag = [AW-1:LINE_BITS+BLK_BITS], line = next LINE_BITS bits, blk = [BLK_BITS-1:0].
REQ-011 din  input  DW  CPU write data.
REQ-012 dout  output  DW  CPU read data, valid while done=1.
REQ-013 done  output  1  one-cycle pulse marking access completion.
REQ-014 busy  output  1  high in every state other than IDLE.
REQ-015 mem_addr  output  AW  backing-memory word address.
REQ-016 mem_rd / mem_wr  output  1 each  memory read/write strobes, held until mem_ack.
REQ-017 mem_wdata  output  DW; mem_rdata  input  DW; mem_ack  input  1  memory handshake.
REQ-018 hit_cnt / miss_cnt  output  16 each  access statistics.

Function
REQ-019 Organisation SHALL be direct-mapped: 2^LINE_BITS lines, each with a valid bit, a TAG_W tag, and 2^BLK_BITS data words.
REQ-020 Hit SHALL be defined as valid[line] AND tag-store[line] == tag.
REQ-021 FSM states SHALL be IDLE, REFILL, WRITE, DONE; the address and din SHALL be latched when req is accepted in IDLE.
REQ-022 Read hit: IDLE -> DONE; done=1 and dout = data[line][blk] on the second edge after req (2-cycle latency).
REQ-023 Read miss: IDLE -> REFILL; fetch words 0..2^BLK_BITS-1 of the line in order, using mem_addr = {tag,line,cnt} and mem_rd=1, writing each word on its mem_ack and then advancing cnt.
REQ-024 After the last-word ack the block SHALL set the valid bit, write the tag, and go to DONE with dout = the requested word.
REQ-025 The write policy SHALL be write-through, no-write-allocate: IDLE -> WRITE, and mem_wr=1 with mem_addr=address and mem_wdata=din is held until mem_ack, then the block goes to DONE.
REQ-026 On a write hit, the cached word SHALL also be updated on the ack edge; a write miss SHALL leave the cache contents and valid bits unchanged.
REQ-027 DONE SHALL last exactly one cycle and then return to IDLE; req is ignored while busy=1.
REQ-028 mem_rd and mem_wr SHALL never both be high; an ack that arrives while neither is high SHALL be ignored.
REQ-029 An access to the line currently being refilled cannot occur; the single-outstanding rule makes it impossible.

Reset
REQ-030 Reset SHALL clear all valid bits, the FSM (to IDLE), the refill counter, the counters, done, busy, mem_rd, mem_wr, mem_addr, mem_wdata and dout.
REQ-031 Data and tag arrays SHALL NOT be reset.
REQ-032 A reset during REFILL SHALL leave the line invalid, and a partial fill SHALL never become valid.

Configuration
REQ-033 When CACHE_STATS_EN is defined, hit_cnt and miss_cnt SHALL each increment once per accepted access (hit or miss) and saturate at 16'hFFFF; writes SHALL count too.
REQ-034 When CACHE_STATS_EN is not defined, the ports SHALL remain and SHALL be tied to 0, with no counter logic present.

Verification
REQ-035 Defaults, after reset: read 11'h0A5 with 0-wait ack -> 8 mem_rd acks to addresses 0xA0..0xA7, done with dout = mem[0x0A5], miss_cnt=1.
REQ-036 Read 11'h0A2 immediately after -> no mem_rd, done two cycles after req, dout = mem[0x0A2], hit_cnt=1.
REQ-037 Write 8'h5C to 11'h0A2 (hit), then read it -> mem_wr once with data 5C, and the following read hits with dout=5C.
REQ-038 Write to 11'h3E0 (miss), then read 11'h3E0 -> the write leaves the cache untouched, and the read misses, refills, and returns the written value.
REQ-039 Aliasing: read 11'h0A5, then 11'h1A5 (same line, different tag) -> both miss; re-reading 0x0A5 misses again.
REQ-040 Assert reset after the 3rd refill ack -> busy=0 and valid cleared; a re-read of the same address misses and performs a full 8-word refill.
